// File: rtl/qar_mem_arbiter_pkg.sv
// Shared types and constants for the qar_core memory-port arbiter.
// Owner IDs tag in-flight reads so returning data reaches the requester that issued them.
package qar_mem_arbiter_pkg;

  // Requester identity carried through the read-return pipe
  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_id_t;

  // Supported memory read latency window (cycles)
  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 4;

  // True when a requested read latency is inside the supported window
  function automatic bit rd_latency_legal(input int lat);
    return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/qar_mem_arbiter_if.sv
// Bus bundle between the two requesters (IF, LS), the arbiter and the memory port.
// slave  : seen from the arbiter (takes requests, drives grants/returns and the memory strobes)
// master : seen from the environment (core pipeline + memory)
interface qar_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  // Instruction-fetch requester (read only)
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // Load/store requester
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  // Shared memory port
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );

endinterface

// File: rtl/qar_mem_arbiter_rd_return_pipe.sv
// Valid/owner shift pipe that tracks outstanding reads for DEPTH cycles.
// The head (last stage) lines up with the cycle in which memory presents the read data.
// Asynchronous reset drops every in-flight entry immediately.
module qar_rd_return_pipe
  import qar_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  port_id_t owner_i,
  output logic     head_valid_o,
  output port_id_t head_owner_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] owner_q;
  logic [DEPTH-1:0] owner_d;

  // Shift every stage one step toward the head and insert the new entry at stage 0
  always_comb begin
    valid_d = (valid_q << 1'b1) | DEPTH'(push_i);
    owner_d = (owner_q << 1'b1) | DEPTH'(owner_i);
  end

  // Pipe registers; reset clears all outstanding reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= {DEPTH{1'b0}};
      owner_q <= {DEPTH{1'b0}};
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  assign head_valid_o = valid_q[DEPTH-1];
  assign head_owner_o = port_id_t'(owner_q[DEPTH-1]);

endmodule

// File: rtl/qar_mem_arbiter.sv
// Memory-port arbiter for qar_core: shares one memory port between instruction fetch (IF)
// and load/store (LS). LS has priority, but IF is guaranteed a grant after STARVE_MAX
// consecutive LS grants while it waits. Read data is steered back by an owner-tagged pipe.
module qar_mem_arbiter
  import qar_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  qar_mem_arbiter_if.slave   bus
);

  localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

  // Reject unsupported latencies at elaboration time
  if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_rd_latency
    $error("qar_mem_arbiter: RD_LATENCY out of supported range");
  end

  logic             grant_if;
  logic             grant_ls;
  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  logic             rd_push;
  port_id_t         rd_owner;
  logic             head_valid;
  port_id_t         head_owner;

  // Pick at most one requester; LS wins a conflict unless IF has waited STARVE_MAX grants
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (!rst_n) begin
      grant_if = 1'b0;
      grant_ls = 1'b0;
    end else if (bus.if_req && bus.ls_req) begin
      if (starve_q == STARVE_LIM) begin
        grant_if = 1'b1;
      end else begin
        grant_ls = 1'b1;
      end
    end else if (bus.ls_req) begin
      grant_ls = 1'b1;
    end else if (bus.if_req) begin
      grant_if = 1'b1;
    end else begin
      grant_if = 1'b0;
      grant_ls = 1'b0;
    end
  end

  assign bus.if_gnt = grant_if;
  assign bus.ls_gnt = grant_ls;

  // Count LS grants taken while IF is waiting; any IF grant or idle IF clears it
  always_comb begin
    starve_d = starve_q;
    if (grant_if || !bus.if_req) begin
      starve_d = {CNT_W{1'b0}};
    end else if (grant_ls && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + CNT_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= {CNT_W{1'b0}};
    end else begin
      starve_q <= starve_d;
    end
  end

  // Drive the memory port from whichever requester holds the grant; idle port is all zero
  always_comb begin
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    case ({grant_ls, grant_if})
      2'b01: begin
        bus.mem_addr = bus.if_addr;
        bus.mem_re   = 1'b1;
      end
      2'b10: begin
        bus.mem_addr  = bus.ls_addr;
        bus.mem_wdata = bus.ls_wdata;
        bus.mem_we    = bus.ls_we;
        bus.mem_re    = ~bus.ls_we;
      end
      default: begin
        bus.mem_addr  = {ADDR_W{1'b0}};
        bus.mem_wdata = {DATA_W{1'b0}};
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
      end
    endcase
  end

  // Every granted read (never a write) enters the return pipe tagged with its owner
  always_comb begin
    rd_push  = grant_if || (grant_ls && !bus.ls_we);
    rd_owner = PORT_IF;
    if (grant_ls) begin
      rd_owner = PORT_LS;
    end else begin
      rd_owner = PORT_IF;
    end
  end

  qar_rd_return_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rd_return_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (rd_push),
    .owner_i      (rd_owner),
    .head_valid_o (head_valid),
    .head_owner_o (head_owner)
  );

  // Steer the returning memory data to the owner of the pipe head; the other port sees zero
  always_comb begin
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = {DATA_W{1'b0}};
    bus.ls_rvalid = 1'b0;
    bus.ls_rdata  = {DATA_W{1'b0}};
    if (head_valid) begin
      case (head_owner)
        PORT_IF: begin
          bus.if_rvalid = 1'b1;
          bus.if_rdata  = bus.mem_rdata;
        end
        PORT_LS: begin
          bus.ls_rvalid = 1'b1;
          bus.ls_rdata  = bus.mem_rdata;
        end
        default: begin
          bus.if_rvalid = 1'b0;
          bus.ls_rvalid = 1'b0;
        end
      endcase
    end else begin
      bus.if_rvalid = 1'b0;
      bus.ls_rvalid = 1'b0;
    end
  end

endmodule
